// File: rtl/bram_read_sequencer_if.sv
// BRAM read port plus downstream valid/ready sample stream.
// The master side is the sequencer; the slave side is the BRAM and the stream sink.
interface bram_read_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] raddr;
  logic              read_en;
  logic              rclke;
  logic [DATA_W-1:0] rdata;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  modport master (
    output raddr, read_en, rclke, m_valid, m_data, m_last,
    input  rdata, m_ready
  );

  modport slave (
    input  raddr, read_en, rclke, m_valid, m_data, m_last,
    output rdata, m_ready
  );
endinterface

// File: rtl/bram_read_sequencer.sv
// Streams a base/length/stride window of a 256x16 BRAM table with looping, abort and back-pressure.
// Optional running XOR checksum output enabled by BRAM_READ_SEQUENCER_CHECKSUM_EN.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing reads while credits allow
// DRAIN | all reads issued, emptying in-flight word and FIFO
module bram_read_sequencer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W:0]   cfg_len,
  input  logic [ADDR_W-1:0] cfg_step,
  input  logic              cfg_loop,
  output logic              busy,
  output logic              done,
`ifdef BRAM_READ_SEQUENCER_CHECKSUM_EN
  output logic [DATA_W-1:0] csum,
`endif
  bram_read_sequencer_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q, base_q, step_q;
  logic [ADDR_W:0]   len_q, rem_q;
  logic              loop_q, inflight_q, inflight_last_q, done_q;
  logic [DATA_W-1:0] fifo_data [2];
  logic              fifo_last [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        count_q;

  logic       pop, push, issue, last_issue, accept_start, abort_act;
  logic [2:0] used;

  assign pop          = (count_q != 2'd0) && bus.m_ready;
  assign abort_act    = abort && (state_q != IDLE);
  assign push         = inflight_q && !abort_act;
  // A word leaving the FIFO this cycle frees its slot, which keeps 1 sample/cycle sustainable.
  assign used         = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue        = (state_q == RUN) && !abort && (used < 3'd2);
  assign last_issue   = issue && (rem_q == (ADDR_W+1)'(1));
  assign accept_start = (state_q == IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && (cfg_len != '0)) state_d = RUN;
      RUN:     if (abort) state_d = IDLE;
               else if (last_issue && !loop_q) state_d = DRAIN;
      DRAIN:   if (abort) state_d = IDLE;
               else if ((count_q == 2'd0) && !inflight_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != IDLE);
    done        = done_q;
    bus.read_en = issue;
    bus.rclke   = issue;
    bus.raddr   = addr_q;
    bus.m_valid = (count_q != 2'd0);
    bus.m_data  = fifo_data[rd_ptr];
    bus.m_last  = fifo_last[rd_ptr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q          <= '0;
      base_q          <= '0;
      step_q          <= '0;
      len_q           <= '0;
      rem_q           <= '0;
      loop_q          <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
      wr_ptr          <= 1'b0;
      rd_ptr          <= 1'b0;
      count_q         <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
    end else begin
      done_q <= (accept_start && (cfg_len == '0)) || ((state_q != IDLE) && (state_d == IDLE));
      if (accept_start) begin
        base_q <= cfg_base;
        step_q <= cfg_step;
        len_q  <= cfg_len;
        loop_q <= cfg_loop;
        addr_q <= cfg_base;
        rem_q  <= cfg_len;
      end else if (issue) begin
        addr_q <= (last_issue && loop_q) ? base_q : addr_q + step_q;
        rem_q  <= (last_issue && loop_q) ? len_q  : rem_q - (ADDR_W+1)'(1);
      end
      inflight_q      <= issue;
      inflight_last_q <= last_issue;
      if (abort_act) begin
        count_q <= 2'd0;
        wr_ptr  <= 1'b0;
        rd_ptr  <= 1'b0;
      end else begin
        if (push) begin
          fifo_data[wr_ptr] <= bus.rdata;
          fifo_last[wr_ptr] <= inflight_last_q;
          wr_ptr            <= ~wr_ptr;
        end
        if (pop) rd_ptr <= ~rd_ptr;
        count_q <= count_q + {1'b0, push} - {1'b0, pop};
      end
    end
  end

`ifdef BRAM_READ_SEQUENCER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            csum <= '0;
    else if (accept_start) csum <= '0;
    else if (pop)          csum <= csum ^ bus.m_data;
  end
`endif

endmodule

// File: tb/tb_bram_read_sequencer.sv
// Directed self-checking bench for bram_read_sequencer with a behavioural 1-cycle-latency BRAM.
module tb_bram_read_sequencer;
  logic       clk = 1'b0;
  logic       rst_n, start, abort, cfg_loop, busy, done;
  logic [7:0] cfg_base, cfg_step;
  logic [8:0] cfg_len;
`ifdef BRAM_READ_SEQUENCER_CHECKSUM_EN
  logic [15:0] csum;
`endif

  bram_read_sequencer_if #(.ADDR_W(8), .DATA_W(16)) bus ();

  bram_read_sequencer #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_base(cfg_base), .cfg_len(cfg_len), .cfg_step(cfg_step), .cfg_loop(cfg_loop),
    .busy(busy), .done(done),
`ifdef BRAM_READ_SEQUENCER_CHECKSUM_EN
    .csum(csum),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [15:0] bram [256];
  always @(posedge clk) if (bus.read_en) bus.rdata <= bram[bus.raddr];

  int checks = 0, errors = 0;
  logic [15:0] got_data [$];
  logic        got_last [$];
  logic [7:0]  raddr_q [$];
  int n_issue = 0, tb_out = 0, credit_err = 0, hold_err = 0;
  logic prev_stall = 1'b0, p;
  logic [15:0] prev_data;
  logic prev_last;

  // Observer: records handshakes and issued addresses, checks credit use and stall hold.
  always @(negedge clk) begin
    if (!rst_n) begin
      tb_out = 0;
      prev_stall = 1'b0;
    end else begin
      p = bus.m_valid && bus.m_ready;
      if (p) begin
        got_data.push_back(bus.m_data);
        got_last.push_back(bus.m_last);
      end
      if (bus.read_en) begin
        raddr_q.push_back(bus.raddr);
        n_issue++;
        if (tb_out - int'(p) >= 2) credit_err++;
      end
      if (prev_stall && (!bus.m_valid || bus.m_data !== prev_data || bus.m_last !== prev_last))
        hold_err++;
      prev_stall = bus.m_valid && !bus.m_ready && !abort;
      prev_data  = bus.m_data;
      prev_last  = bus.m_last;
      if (abort && busy) tb_out = 0;
      else tb_out = tb_out + int'(bus.read_en) - int'(p);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    got_data.delete();
    got_last.delete();
    raddr_q.delete();
  endtask

  task automatic do_start(input logic [7:0] b, input logic [8:0] l, input logic [7:0] s, input logic lp);
    cfg_base = b; cfg_len = l; cfg_step = s; cfg_loop = lp;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 60) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; bus.m_ready = 1'b1;
    cfg_base = '0; cfg_len = '0; cfg_step = '0; cfg_loop = 1'b0;
    #12;
    checks++;
    if ({busy, done, bus.m_valid, bus.read_en, bus.rclke, bus.m_last} !== 6'b0 ||
        bus.raddr !== 8'h00 || bus.m_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b valid=%b re=%b rclke=%b last=%b raddr=%h data=%h want all 0",
               busy, done, bus.m_valid, bus.read_en, bus.rclke, bus.m_last, bus.raddr, bus.m_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_pass();
    logic [15:0] exp_d [4] = '{16'h079d, 16'h07aa, 16'h07b5, 16'h07bf};
    int n;
    clear_logs();
    bus.m_ready = 1'b1;
    do_start(8'h80, 9'd4, 8'd1, 1'b0);
    checks++;
    if (busy !== 1'b1 || bus.m_valid !== 1'b0) begin
      errors++; $display("FAIL start_latency_s1 got busy=%b valid=%b want 1 0", busy, bus.m_valid);
    end
    tick();
    checks++;
    if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL start_latency_s2 got valid=%b want 0", bus.m_valid); end
    tick();
    checks++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== 16'h079d) begin
      errors++; $display("FAIL start_latency_s3 got valid=%b data=%h want 1 079d", bus.m_valid, bus.m_data);
    end
    wait_done(n);
    n = n + 3;
    checks++;
    if (n != 8) begin errors++; $display("FAIL single_done_cycle got %0d want 8", n); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_at_done got %b want 0", busy); end
    checks++;
    if (got_data.size() != 4) begin
      errors++; $display("FAIL single_count got %0d want 4", got_data.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_data[i] !== exp_d[i] || got_last[i] !== (i == 3)) begin
          errors++;
          $display("FAIL single_sample%0d got %h last=%b want %h last=%b", i, got_data[i], got_last[i], exp_d[i], i == 3);
        end
      end
    end
`ifdef BRAM_READ_SEQUENCER_CHECKSUM_EN
    checks++;
    if (csum !== 16'h003d) begin errors++; $display("FAIL single_csum got %h want 003d", csum); end
`endif
    tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle got %b want 0", done); end
  endtask

  task automatic test_wrap();
    int n;
    clear_logs();
    do_start(8'hff, 9'd2, 8'd1, 1'b0);
    wait_done(n);
    checks++;
    if (n >= 60) begin errors++; $display("FAIL wrap_timeout got %0d cycles want done", n); end
    checks++;
    if (raddr_q.size() != 2 || raddr_q[0] !== 8'hff || raddr_q[1] !== 8'h00) begin
      errors++; $display("FAIL wrap_raddr got n=%0d %h %h want ff 00", raddr_q.size(), raddr_q[0], raddr_q[1]);
    end
    checks++;
    if (got_data.size() != 2 || got_data[0] !== 16'hf820 || got_data[1] !== 16'h0000 ||
        got_last[0] !== 1'b0 || got_last[1] !== 1'b1) begin
      errors++; $display("FAIL wrap_data got n=%0d %h %h want f820 0000", got_data.size(), got_data[0], got_data[1]);
    end
  endtask

  task automatic test_stride_backpressure();
    logic [15:0] exp_d [3] = '{16'h079d, 16'h07b5, 16'h07c8};
    int i;
    clear_logs();
    hold_err = 0; credit_err = 0;
    do_start(8'h80, 9'd3, 8'd2, 1'b0);
    i = 0;
    while (!done && i < 60) begin
      bus.m_ready = ((i % 4) == 0) || ((i % 4) == 3);
      tick();
      i++;
    end
    bus.m_ready = 1'b1;
    checks++;
    if (i >= 60) begin errors++; $display("FAIL stride_timeout got %0d cycles want done", i); end
    checks++;
    if (got_data.size() != 3) begin
      errors++; $display("FAIL stride_count got %0d want 3", got_data.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (got_data[k] !== exp_d[k] || got_last[k] !== (k == 2)) begin
          errors++; $display("FAIL stride_sample%0d got %h want %h", k, got_data[k], exp_d[k]);
        end
      end
    end
    checks++;
    if (hold_err != 0) begin errors++; $display("FAIL stride_hold got %0d violations want 0", hold_err); end
    checks++;
    if (credit_err != 0) begin errors++; $display("FAIL stride_credit got %0d violations want 0", credit_err); end
  endtask

  task automatic test_loop_abort();
    clear_logs();
    bus.m_ready = 1'b1;
    do_start(8'h80, 9'd2, 8'd1, 1'b1);
    repeat (10) tick();
    abort = 1'b1;
    #1;
    checks++;
    if (bus.read_en !== 1'b0) begin errors++; $display("FAIL abort_no_issue got re=%b want 0", bus.read_en); end
    tick();
    abort = 1'b0;
    checks++;
    if (bus.m_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_response got valid=%b done=%b busy=%b want 0 1 0", bus.m_valid, done, busy);
    end
    checks++;
    if (got_data.size() != 9) begin
      errors++; $display("FAIL loop_count got %0d want 9", got_data.size());
    end else begin
      for (int k = 0; k < 9; k++) begin
        checks++;
        if (got_data[k] !== ((k % 2) ? 16'h07aa : 16'h079d) || got_last[k] !== ((k % 2) == 1)) begin
          errors++; $display("FAIL loop_sample%0d got %h last=%b", k, got_data[k], got_last[k]);
        end
      end
    end
`ifdef BRAM_READ_SEQUENCER_CHECKSUM_EN
    checks++;
    if (csum !== 16'h079d) begin errors++; $display("FAIL abort_csum got %h want 079d", csum); end
`endif
    tick();
    checks++;
    if (done !== 1'b0 || bus.m_valid !== 1'b0) begin
      errors++; $display("FAIL abort_settle got done=%b valid=%b want 0 0", done, bus.m_valid);
    end
  endtask

  task automatic test_edge_cases();
    int n, base_issue;
    // zero length
    base_issue = n_issue;
    do_start(8'h80, 9'd0, 8'd1, 1'b0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL len0_response got done=%b busy=%b want 1 0", done, busy);
    end
    tick(); tick();
    checks++;
    if (n_issue != base_issue || busy !== 1'b0) begin
      errors++; $display("FAIL len0_no_read got issues=%0d busy=%b want 0 0", n_issue - base_issue, busy);
    end
    // start while busy is ignored
    clear_logs();
    do_start(8'h80, 9'd2, 8'd1, 1'b0);
    do_start(8'hff, 9'd4, 8'd1, 1'b1);
    wait_done(n);
    repeat (3) tick();
    checks++;
    if (got_data.size() != 2 || got_data[0] !== 16'h079d || got_data[1] !== 16'h07aa || busy !== 1'b0) begin
      errors++; $display("FAIL start_while_busy got n=%0d %h %h busy=%b want 2 079d 07aa 0",
                         got_data.size(), got_data[0], got_data[1], busy);
    end
    // start and abort together in IDLE
    clear_logs();
    abort = 1'b1;
    do_start(8'h81, 9'd1, 8'd1, 1'b0);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL start_abort_idle got busy=%b want 1", busy); end
    wait_done(n);
    checks++;
    if (got_data.size() != 1 || got_data[0] !== 16'h07aa || got_last[0] !== 1'b1) begin
      errors++; $display("FAIL start_abort_data got n=%0d %h want 1 07aa", got_data.size(), got_data[0]);
    end
  endtask

  task automatic test_reset_mid_run();
    int base_issue;
    do_start(8'h80, 9'd2, 8'd1, 1'b1);
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, bus.m_valid, bus.read_en, bus.rclke, bus.m_last} !== 6'b0 ||
        bus.raddr !== 8'h00 || bus.m_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid_run got busy=%b valid=%b re=%b raddr=%h data=%h want all 0",
               busy, bus.m_valid, bus.read_en, bus.raddr, bus.m_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    base_issue = n_issue;
    repeat (4) tick();
    checks++;
    if (bus.m_valid !== 1'b0 || busy !== 1'b0 || n_issue != base_issue) begin
      errors++; $display("FAIL reset_no_replay got valid=%b busy=%b issues=%0d want 0 0 0",
                         bus.m_valid, busy, n_issue - base_issue);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) bram[i] = 16'(i * 3 + 16'h1000);
    bram[8'h80] = 16'h079d; bram[8'h81] = 16'h07aa; bram[8'h82] = 16'h07b5;
    bram[8'h83] = 16'h07bf; bram[8'h84] = 16'h07c8;
    bram[8'hff] = 16'hf820; bram[8'h00] = 16'h0000;
    bus.rdata = 16'h0000;
    test_reset();
    test_single_pass();
    test_wrap();
    test_stride_backpressure();
    test_loop_abort();
    test_edge_cases();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end
endmodule
